// File: rtl/logo_bouncer.sv
// rtl/logo_bouncer.sv - per-frame bouncing logo position, bounce/corner pulses and palette index.
// Optional COLOR_LFSR_EN: palette index on bounce taken from an 8-bit LFSR instead of a 1..7 counter.
`timescale 1ns/1ps
module logo_bouncer #(
    parameter int H_VISIBLE       = 640,
    parameter int V_VISIBLE       = 480,
    parameter int LOGO_W          = 64,
    parameter int LOGO_H          = 32,
    parameter int SPEED           = 1,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic        clk_25_175,
    input  logic        rst,
    input  logic [31:0] frame,
    input  logic        pause,
    output logic [9:0]  logo_x,
    output logic [8:0]  logo_y,
    output logic [2:0]  color_idx,
    output logic        bounce,
    output logic        corner_hit
);

    localparam logic signed [10:0] MAX_X    = 11'(H_VISIBLE - LOGO_W);
    localparam logic signed [10:0] MAX_Y    = 11'(V_VISIBLE - LOGO_H);
    localparam logic signed [10:0] STEP     = 11'(SPEED);
    localparam int                 DIV_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

    logic [31:0]      frame_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic [2:0]       color_q, color_d;
    logic             bounce_q, bounce_d;
    logic             corner_q, corner_d;

    logic              frame_tick;
    logic              step;
    logic signed [10:0] nx, ny;
    logic              hit_x, hit_y;

`ifdef COLOR_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
`endif

    always_comb begin
        frame_tick = (frame != frame_q);
        div_d      = div_q;
        if (frame_tick) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        // Pause only masks the step; the divider keeps its phase with the frame counter.
        step = frame_tick && (div_q == DIV_LAST) && !pause;

        nx    = dir_x_q ? ($signed({1'b0, x_q}) + STEP) : ($signed({1'b0, x_q}) - STEP);
        ny    = dir_y_q ? ($signed({2'b00, y_q}) + STEP) : ($signed({2'b00, y_q}) - STEP);
        hit_x = dir_x_q ? (nx >= MAX_X) : (nx <= 11'sd0);
        hit_y = dir_y_q ? (ny >= MAX_Y) : (ny <= 11'sd0);

        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (step) begin
            if (hit_x) begin
                x_d     = dir_x_q ? MAX_X[9:0] : '0;
                dir_x_d = !dir_x_q;
            end else begin
                x_d = nx[9:0];
            end
            if (hit_y) begin
                y_d     = dir_y_q ? MAX_Y[8:0] : '0;
                dir_y_d = !dir_y_q;
            end else begin
                y_d = ny[8:0];
            end
        end

        bounce_d = step && (hit_x || hit_y);
        corner_d = step && hit_x && hit_y;
        color_d  = color_q;
`ifdef COLOR_LFSR_EN
        lfsr_d = step ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
        if (bounce_d) begin
            color_d = (lfsr_q[2:0] == 3'd0) ? 3'd1 : lfsr_q[2:0];
        end
`else
        if (bounce_d) begin
            color_d = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
        end
`endif
    end

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            frame_q  <= '0;
            div_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            color_q  <= 3'd1;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            frame_q  <= frame;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            color_q  <= color_d;
            bounce_q <= bounce_d;
            corner_q <= corner_d;
        end
    end

`ifdef COLOR_LFSR_EN
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign logo_x     = x_q;
    assign logo_y     = y_q;
    assign color_idx  = color_q;
    assign bounce     = bounce_q;
    assign corner_hit = corner_q;

endmodule

// File: tb/tb_logo_bouncer.sv
// tb/tb_logo_bouncer.sv - self-checking bench for logo_bouncer against a behavioural motion model.
`timescale 1ns/1ps
module tb_logo_bouncer;

    localparam int NI = 2;
    localparam int P_MAXX [NI] = '{576, 577};
    localparam int P_MAXY [NI] = '{448, 448};
    localparam int P_SPD  [NI] = '{1, 5};
    localparam int P_FPS  [NI] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] frame = 32'd0;
    logic        pause = 1'b0;

    logic [9:0] lx [NI];
    logic [8:0] ly [NI];
    logic [2:0] ci [NI];
    logic       bo [NI];
    logic       co [NI];

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one entry per DUT instance.
    int          mx [NI], my [NI], mdx [NI], mdy [NI], mcol [NI], mdiv [NI], mlfsr [NI];
    logic        mb [NI], mc [NI];
    logic [31:0] mfq;

    always #20 clk = ~clk;

    logo_bouncer dut0 (
        .clk_25_175(clk), .rst(rst), .frame(frame), .pause(pause),
        .logo_x(lx[0]), .logo_y(ly[0]), .color_idx(ci[0]), .bounce(bo[0]), .corner_hit(co[0])
    );

    logo_bouncer #(.LOGO_W(63), .SPEED(5), .FRAMES_PER_STEP(3)) dut1 (
        .clk_25_175(clk), .rst(rst), .frame(frame), .pause(pause),
        .logo_x(lx[1]), .logo_y(ly[1]), .color_idx(ci[1]), .bounce(bo[1]), .corner_hit(co[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic move_axis(input int p_in, input int d_in, input int m, input int s,
                             output int p, output int d, output logic b);
        p = p_in;
        d = d_in;
        b = 1'b0;
        if (d == 1) begin
            p = p + s;
            if (p >= m) begin p = m; d = 0; b = 1'b1; end
        end else begin
            p = p - s;
            if (p <= 0) begin p = 0; d = 1; b = 1'b1; end
        end
    endtask

    // Reference model: advances on every clock edge, resets on the async reset edge.
    initial begin : model
        logic st, bx, by;
        int   np, nd, fb;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mfq = 32'd0;
                for (int i = 0; i < NI; i++) begin
                    mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 1; mcol[i] = 1;
                    mdiv[i] = 0; mlfsr[i] = 8'h5A; mb[i] = 1'b0; mc[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < NI; i++) begin
                    mb[i] = 1'b0;
                    mc[i] = 1'b0;
                    st    = 1'b0;
                    if (frame != mfq) begin
                        mdiv[i] = (mdiv[i] + 1) % P_FPS[i];
                        st      = (mdiv[i] == 0) && !pause;
                    end
                    if (st) begin
                        move_axis(mx[i], mdx[i], P_MAXX[i], P_SPD[i], np, nd, bx);
                        mx[i] = np; mdx[i] = nd;
                        move_axis(my[i], mdy[i], P_MAXY[i], P_SPD[i], np, nd, by);
                        my[i] = np; mdy[i] = nd;
                        if (bx || by) begin
                            mb[i] = 1'b1;
`ifdef COLOR_LFSR_EN
                            mcol[i] = ((mlfsr[i] % 8) == 0) ? 1 : (mlfsr[i] % 8);
`else
                            mcol[i] = (mcol[i] % 7) + 1;
`endif
                        end
                        mc[i]    = bx && by;
                        fb       = ((mlfsr[i] >> 7) ^ (mlfsr[i] >> 5) ^ (mlfsr[i] >> 4) ^ (mlfsr[i] >> 3)) & 1;
                        mlfsr[i] = ((mlfsr[i] << 1) | fb) & 8'hFF;
                    end
                end
                mfq = frame;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("dut%0d.logo_x", i), 32'(lx[i]), 32'(mx[i]));
                    chk($sformatf("dut%0d.logo_y", i), 32'(ly[i]), 32'(my[i]));
                    chk($sformatf("dut%0d.color_idx", i), 32'(ci[i]), 32'(mcol[i]));
                    chk($sformatf("dut%0d.bounce", i), 32'(bo[i]), 32'(mb[i]));
                    chk($sformatf("dut%0d.corner_hit", i), 32'(co[i]), 32'(mc[i]));
                end
            end
        end
    end

    // Inputs change 2 ns after an edge; returns 2 ns after the edge that consumed the change.
    task automatic frame_step();
        frame = frame + 32'd1;
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int r;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_x", 32'(lx[0]), 32'd0);
        chk("reset_y", 32'(ly[0]), 32'd0);
        chk("reset_color", 32'(ci[0]), 32'd1);
        chk("reset_bounce", 32'(bo[0]), 32'd0);

        frame = 32'd1;
        #5;
        chk("latency_x_before", 32'(lx[0]), 32'd0);
        chk("latency_color_before", 32'(ci[0]), 32'd1);
        @(posedge clk);
        #2;
        chk("latency_x_after", 32'(lx[0]), 32'd1);
        chk("latency_y_after", 32'(ly[0]), 32'd1);

        for (int n = 2; n <= 4032; n++) begin
            frame_step();
            if (n == 345) chk("clamp_x_115", 32'(lx[1]), 32'd575);
            if (n == 348) begin
                chk("clamp_x_116", 32'(lx[1]), 32'd577);
                chk("clamp_bounce_116", 32'(bo[1]), 32'd1);
            end
            if (n == 351) chk("clamp_x_117", 32'(lx[1]), 32'd572);
            if (n == 448) begin
                chk("ybounce_y", 32'(ly[0]), 32'd448);
                chk("ybounce_pulse", 32'(bo[0]), 32'd1);
`ifndef COLOR_LFSR_EN
                chk("ybounce_color", 32'(ci[0]), 32'd2);
`endif
            end
            if (n == 449) begin
                chk("ybounce_next_y", 32'(ly[0]), 32'd447);
                chk("ybounce_next_x", 32'(lx[0]), 32'd449);
                chk("ybounce_pulse_clear", 32'(bo[0]), 32'd0);
            end
            if (n == 4032) begin
                chk("corner_x", 32'(lx[0]), 32'd576);
                chk("corner_y", 32'(ly[0]), 32'd448);
                chk("corner_hit", 32'(co[0]), 32'd1);
                chk("corner_bounce", 32'(bo[0]), 32'd1);
`ifndef COLOR_LFSR_EN
                chk("corner_color", 32'(ci[0]), 32'd2);
`endif
            end
        end

        pause = 1'b1;
        @(posedge clk);
        #2;
        chk("corner_pulse_clear", 32'(co[0]), 32'd0);
        repeat (6) frame_step();
        chk("pause_x0", 32'(lx[0]), 32'd576);
        chk("pause_y0", 32'(ly[0]), 32'd448);
        chk("pause_x1", 32'(lx[1]), 32'd237);
        chk("pause_y1", 32'(ly[1]), 32'd420);
        pause = 1'b0;
        frame_step();
        frame_step();
        chk("release_hold_x1", 32'(lx[1]), 32'd237);
        frame_step();
        chk("release_step_x1", 32'(lx[1]), 32'd232);
        chk("release_step_y1", 32'(ly[1]), 32'd425);
        chk("release_x0", 32'(lx[0]), 32'd573);
        chk("release_y0", 32'(ly[0]), 32'd445);

        for (int k = 0; k < 3000; k++) begin
            r     = $urandom_range(0, 9);
            pause = ($urandom_range(0, 3) == 0);
            if (r < 6)       frame = frame + 32'd1;
            else if (r == 6) frame = $urandom;
            @(posedge clk);
            #2;
        end

        pause = 1'b0;
        for (int k = 0; k < 1500 && mx[0] != 200; k++) frame_step();
        chk("seek_x200", 32'(lx[0]), 32'd200);
        #8 rst = 1'b1;
        #1;
        chk("async_rst_x", 32'(lx[0]), 32'd0);
        chk("async_rst_y", 32'(ly[0]), 32'd0);
        chk("async_rst_color", 32'(ci[0]), 32'd1);
        chk("async_rst_bounce", 32'(bo[0]), 32'd0);
        chk("async_rst_x1", 32'(lx[1]), 32'd0);
        if (frame == 32'd0) frame = 32'd7;
        @(posedge clk);
        #10 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post_rst_first_x", 32'(lx[0]), 32'd1);
        chk("post_rst_first_y", 32'(ly[0]), 32'd1);
        chk("post_rst_hold_x1", 32'(lx[1]), 32'd0);
        repeat (4) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
